wptr_full: RTL and testbench

- Write-side pointer and full-flag logic for the dual-clock async FIFO.
- Pairs with the read-side pointer/empty block; lives entirely in the write clock domain.
- Keeps the binary and Gray write pointers and produces the RAM write address.
- Synchronises the read-domain Gray pointer through two flops, then derives full, almost-full, fill level and a sticky overflow flag.

---
 rtl/wptr_full.sv | 181 ++++++++++++++++++
 tb/tb_wptr_full.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// -----------------------------------------------------------------------------
// wptr_full
//
// Write-side pointer and full-flag logic for a dual-clock asynchronous FIFO.
// This block sits entirely in the write clock domain. Its partner is the
// read-side pointer/empty block.
//
// It keeps the binary write pointer (wbin_r) and a registered Gray copy (wptr).
// The Gray copy is what crosses into the read domain. The Gray read pointer
// arrives from the read domain and passes through a two-flop synchroniser.
// The synchronised value then drives the full flag, the almost-full flag,
// the write-side fill level and a sticky overflow flag.
//
// Parameters
//   ASIZE     : address width; FIFO depth is 2**ASIZE
//   AF_MARGIN : almost-full asserts when free entries <= AF_MARGIN
//               (meaningful range 1 .. 2**ASIZE-1)
//
// Ports
//   wclk         in   1        write clock; all state changes on its rising edge
//   wrstn        in   1        asynchronous active-low reset
//   wen          in   1        write request from the producer
//   ovf_clr      in   1        synchronous clear of woverflow
//   rptr         in   ASIZE+1  Gray read pointer, still in the read clock domain
//   waddr        out  ASIZE    RAM write address (low bits of the binary pointer)
//   wptr         out  ASIZE+1  registered Gray write pointer for the read domain
//   wfull        out  1        registered full flag
//   walmost_full out  1        registered almost-full flag
//   wlevel       out  ASIZE+1  registered write-side occupancy, 0 .. 2**ASIZE
//   woverflow    out  1        sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module wptr_full #(
  parameter int ASIZE     = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             wrstn,
  input  logic             wen,
  input  logic             ovf_clr,
  input  logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow
);

  localparam int PW = ASIZE + 1;

  // Occupancy value of a completely full FIFO.
  localparam logic [PW-1:0] DEPTH = {1'b1, {ASIZE{1'b0}}};

  // The Gray pointers are one lap apart when the FIFO is full. In that case
  // they differ in exactly their two MSBs. This mask flips those two bits.
  // Building it from DEPTH keeps it legal for ASIZE = 1.
  localparam logic [PW-1:0] FULL_MASK = DEPTH | (DEPTH >> 1);

  localparam logic [PW-1:0] AF_LIMIT = PW'(AF_MARGIN);

  // Binary to Gray conversion.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary conversion: prefix XOR taken from the MSB down.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rq1_r;
  logic [PW-1:0] rq2_r;
  logic          wfull_r;
  logic          walmost_full_r;
  logic [PW-1:0] wlevel_r;
  logic          woverflow_r;

  logic          winc_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_next_s;
  logic [PW-1:0] free_next_s;
  logic          full_next_s;
  logic          almost_full_next_s;
  logic          overflow_next_s;

  // Two-flop synchroniser for the read-domain Gray pointer.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      rq1_r <= {PW{1'b0}};
      rq2_r <= {PW{1'b0}};
    end else begin
      rq1_r <= rptr;
      rq2_r <= rq1_r;
    end
  end

  // Next-state pointer, level and flag computation.
  // Only the synchronised rq2_r is used. A read that frees a slot therefore
  // reaches the flags late, so the flags stay pessimistic.
  always_comb begin
    winc_s             = 1'b0;
    wbin_next_s        = wbin_r;
    wgray_next_s       = wptr_r;
    rbin_s             = {PW{1'b0}};
    level_next_s       = wlevel_r;
    free_next_s        = {PW{1'b0}};
    full_next_s        = 1'b0;
    almost_full_next_s = 1'b0;

    winc_s       = wen & ~wfull_r;
    wbin_next_s  = wbin_r + {{ASIZE{1'b0}}, winc_s};
    wgray_next_s = bin2gray(wbin_next_s);
    rbin_s       = gray2bin(rq2_r);

    // Modulo-2**PW difference. The extra pointer bit keeps the result in the
    // range 0 .. DEPTH across wrap-around.
    level_next_s = wbin_next_s - rbin_s;
    free_next_s  = DEPTH - level_next_s;

    full_next_s        = (wgray_next_s == (rq2_r ^ FULL_MASK));
    almost_full_next_s = (free_next_s <= AF_LIMIT);
  end

  // Sticky overflow: a write attempted while full sets the flag, and the set
  // takes priority over a clear in the same cycle.
  always_comb begin
    overflow_next_s = woverflow_r;
    if (wen && wfull_r) begin
      overflow_next_s = 1'b1;
    end else if (ovf_clr) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = woverflow_r;
    end
  end

  // Write pointer registers.
  // The Gray copy is registered so that the read domain only ever samples a
  // clean value.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wbin_r <= {PW{1'b0}};
      wptr_r <= {PW{1'b0}};
    end else begin
      wbin_r <= wbin_next_s;
      wptr_r <= wgray_next_s;
    end
  end

  // Status registers: full, almost-full, level and overflow.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wlevel_r       <= {PW{1'b0}};
      woverflow_r    <= 1'b0;
    end else begin
      wfull_r        <= full_next_s;
      walmost_full_r <= almost_full_next_s;
      wlevel_r       <= level_next_s;
      woverflow_r    <= overflow_next_s;
    end
  end

  assign waddr        = wbin_r[ASIZE-1:0];
  assign wptr         = wptr_r;
  assign wfull        = wfull_r;
  assign walmost_full = walmost_full_r;
  assign wlevel       = wlevel_r;
  assign woverflow    = woverflow_r;

endmodule

// File: tb/tb_wptr_full.sv
// -----------------------------------------------------------------------------
// tb_wptr_full
//
// Directed testbench for wptr_full with ASIZE=4 and AF_MARGIN=2.
// Inputs are driven 1 time unit after each rising edge of wclk.
// Outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_wptr_full;

  logic       wclk;
  logic       wrstn;
  logic       wen;
  logic       ovf_clr;
  logic [4:0] rptr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int checks;
  int errors;

  wptr_full #(
    .ASIZE     (4),
    .AF_MARGIN (2)
  ) dut (
    .wclk         (wclk),
    .wrstn        (wrstn),
    .wen          (wen),
    .ovf_clr      (ovf_clr),
    .rptr         (rptr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then move 1 time unit past it.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int popcount5(input logic [4:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 5; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_waddr"}, 32'(waddr), 32'd0);
    check({tag, "_wptr"}, 32'(wptr), 32'd0);
    check({tag, "_wfull"}, 32'(wfull), 32'd0);
    check({tag, "_walmost_full"}, 32'(walmost_full), 32'd0);
    check({tag, "_wlevel"}, 32'(wlevel), 32'd0);
    check({tag, "_woverflow"}, 32'(woverflow), 32'd0);
  endtask

  initial begin
    logic [4:0] prev_wptr;
    int         max_level;
    int         full_seen;

    checks  = 0;
    errors  = 0;
    wrstn   = 1'b0;
    wen     = 1'b0;
    ovf_clr = 1'b0;
    rptr    = 5'd0;

    // ---- Reset values ----
    #12;
    check_all_zero("reset");
    step();
    wrstn = 1'b1;
    step();
    step();
    check_all_zero("idle");

    // ---- Fill 16 entries with rptr held at 0 ----
    wen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_waddr%0d", i), 32'(waddr), 32'(i));
      step();
      check($sformatf("fill_wlevel%0d", i), 32'(wlevel), 32'(i + 1));
      check($sformatf("fill_af%0d", i), 32'(walmost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      check($sformatf("fill_full%0d", i), 32'(wfull), (i + 1 == 16) ? 32'd1 : 32'd0);
    end
    check("full_wptr", 32'(wptr), 32'(5'b11000));

    // ---- Overflow while full ----
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ovf_set%0d", k), 32'(woverflow), 32'd1);
      check($sformatf("ovf_wptr%0d", k), 32'(wptr), 32'(5'b11000));
      check($sformatf("ovf_wlevel%0d", k), 32'(wlevel), 32'd16);
    end
    wen     = 1'b0;
    ovf_clr = 1'b1;
    step();
    check("ovf_clr", 32'(woverflow), 32'd0);
    wen     = 1'b1;
    ovf_clr = 1'b1;
    step();
    check("ovf_set_wins", 32'(woverflow), 32'd1);
    check("ovf_set_wins_wptr", 32'(wptr), 32'(5'b11000));
    wen     = 1'b0;
    ovf_clr = 1'b0;

    // ---- Read of one entry: wfull clears at the 3rd edge ----
    rptr = 5'b00001;
    step();
    check("rd_full_e1", 32'(wfull), 32'd1);
    step();
    check("rd_full_e2", 32'(wfull), 32'd1);
    step();
    check("rd_full_e3", 32'(wfull), 32'd0);
    check("rd_wlevel_e3", 32'(wlevel), 32'd15);
    check("rd_af_e3", 32'(walmost_full), 32'd1);
    wen = 1'b1;
    step();
    check("refill_full", 32'(wfull), 32'd1);
    check("refill_wlevel", 32'(wlevel), 32'd16);
    check("refill_wptr", 32'(wptr), 32'(5'b11001));
    wen = 1'b0;

    // ---- Wrap-around: 40 writes, read pointer trailing by 4 edges ----
    // rptr held during the cycle before edge n+1 is wptr from edge n-3.
    // Through the synchroniser, the level settles at min(n, 6).
    wrstn = 1'b0;
    rptr  = 5'd0;
    step();
    wrstn = 1'b1;
    step();
    check_all_zero("rst2");
    prev_wptr = wptr;
    max_level = 0;
    full_seen = 0;
    wen = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      check($sformatf("wrap_wptr%0d", n), 32'(wptr), 32'(gray5(n)));
      check($sformatf("wrap_gray1bit%0d", n), 32'(popcount5(wptr ^ prev_wptr)), 32'd1);
      check($sformatf("wrap_wlevel%0d", n), 32'(wlevel), (n < 6) ? 32'(n) : 32'd6);
      if (int'(wlevel) > max_level) max_level = int'(wlevel);
      if (wfull) full_seen = 1;
      prev_wptr = wptr;
      rptr = (n >= 3) ? gray5(n - 3) : 5'd0;
    end
    wen = 1'b0;
    check("wrap_final_waddr", 32'(waddr), 32'd8);
    check("wrap_max_level_le6", (max_level <= 6) ? 32'd1 : 32'd0, 32'd1);
    check("wrap_never_full", 32'(full_seen), 32'd0);

    // ---- Asynchronous reset mid-burst at wlevel=9 ----
    wrstn = 1'b0;
    rptr  = 5'd0;
    step();
    wrstn = 1'b1;
    step();
    wen = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("pre_rst_wlevel", 32'(wlevel), 32'd9);
    check("pre_rst_waddr", 32'(waddr), 32'd9);
    #2;
    wrstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    wen = 1'b0;
    step();
    check_all_zero("async_rst_held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
